// File: rtl/g2_readout_pkg.sv
// Shared types and helpers for the g2 histogram readout block.
// The frame length helper is shared so that every user agrees on frame size.
package g2_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        HDR,
        BIN,
        CKS
    } state_e;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    // Total bytes in one frame: two sync bytes, two count bytes, all bin bytes, optional checksum.
    function automatic int frame_len(input int nbins, input int binW, input bit cks);
        return 4 + nbins * (binW / 8) + (cks ? 1 : 0);
    endfunction

endpackage

// File: rtl/g2_byte_ser.sv
// Word-to-byte serializer: holds one BIN_W-bit word and shifts it out LSB first.
// The output byte is the low byte of the word register, so oD/oV are registered.
// iR reasserts in the cycle the last byte is taken, so back-to-back words leave no gap.
module g2_byte_ser #(
    parameter int BIN_W = 32
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [BIN_W-1:0] iDat,
    input  logic             iV,
    output logic             iR,
    output logic [7:0]       oD,
    output logic             oV,
    input  logic             oR,
    output logic             oLast
);

    localparam int NB = BIN_W / 8;
    localparam int IW = $clog2(NB + 1);

    logic [BIN_W-1:0] word_q;
    logic [IW-1:0]    left_q;
    logic             byteTake;

    assign oV       = (left_q != '0);
    assign oD       = word_q[7:0];
    assign oLast    = (left_q == IW'(1));
    assign byteTake = oV && oR;
    assign iR       = !oV || (byteTake && oLast);

    // Load a new word when allowed, otherwise shift one byte out per accepted transfer.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            word_q <= '0;
            left_q <= '0;
        end else if (iV && iR) begin
            word_q <= iDat;
            left_q <= IW'(NB);
        end else if (byteTake) begin
            word_q <= word_q >> 8;
            left_q <= left_q - 1'b1;
        end
    end

endmodule

// File: rtl/g2_readout.sv
// Host-side reader for the g2 calculator histogram dump.
// Triggers the calculator via g2Rst, then frames the NBINS words as:
// SYNC0, SYNC1, count LSB, count MSB, bin bytes LSB first, optional checksum.
// Optional feature macro: G2_READOUT_CKSUM_EN adds the trailing checksum byte.
module g2_readout
    import g2_readout_pkg::*;
#(
    parameter int         NBINS    = 1024,
    parameter int         BIN_W    = 32,
    parameter int         TRIG_LEN = 2,
    parameter logic [7:0] SYNC0    = SYNC0_DEF,
    parameter logic [7:0] SYNC1    = SYNC1_DEF
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             g2Rst,
    input  logic [BIN_W-1:0] g2Dat,
    input  logic             g2V,
    output logic             g2R,
    output logic [7:0]       oD,
    output logic             oV,
    input  logic             oR
);

    localparam int          CW    = $clog2(NBINS + 1);
    localparam int          TW    = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam logic [15:0] CNT16 = 16'(NBINS);

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          g2Rst_q;
    logic [7:0]    ctlD_q;
    logic          ctlV_q;
    logic [1:0]    hdrIdx_q;
    logic [TW-1:0] trigCnt_q;
    logic [CW-1:0] binCnt_q;

    logic          serIV;
    logic          serIR;
    logic [7:0]    serD;
    logic          serV;
    logic          serLast;
    logic          ctlTake;
    logic          serTake;
    logic          binsLeft;
    logic          hdrEnd;
    logic          winOpen;
    logic          frameEnd;

`ifdef G2_READOUT_CKSUM_EN
    logic [7:0]    sum_q;
    logic [7:0]    cksByte_d;

    assign cksByte_d = 8'd0 - (sum_q + serD);
`endif

    assign ctlTake  = ctlV_q && oR;
    assign serTake  = serV && oR;
    assign binsLeft = (binCnt_q < CW'(NBINS));
    assign hdrEnd   = (state_q == HDR) && (hdrIdx_q == 2'd3) && ctlTake;
    assign winOpen  = binsLeft && ((state_q == BIN) || hdrEnd);
    assign g2R      = winOpen && serIR;
    assign serIV    = g2V && winOpen;
    assign frameEnd = (state_q == BIN) && !binsLeft && serTake && serLast;

    assign oV    = ctlV_q || serV;
    assign oD    = ctlV_q ? ctlD_q : serD;
    assign busy  = busy_q;
    assign done  = done_q;
    assign g2Rst = g2Rst_q;

    g2_byte_ser #(
        .BIN_W (BIN_W)
    ) u_ser (
        .clk   (clk),
        .RST   (RST),
        .iDat  (g2Dat),
        .iV    (serIV),
        .iR    (serIR),
        .oD    (serD),
        .oV    (serV),
        .oR    (oR),
        .oLast (serLast)
    );

    // Frame sequencer: trigger pulse, header bytes, bin drain and optional checksum.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            g2Rst_q   <= 1'b1;
            ctlD_q    <= '0;
            ctlV_q    <= 1'b0;
            hdrIdx_q  <= '0;
            trigCnt_q <= '0;
            binCnt_q  <= '0;
`ifdef G2_READOUT_CKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (g2V && g2R) begin
                binCnt_q <= binCnt_q + 1'b1;
            end
`ifdef G2_READOUT_CKSUM_EN
            if (serTake) begin
                sum_q <= sum_q + serD;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= TRIG;
                        busy_q    <= 1'b1;
                        g2Rst_q   <= 1'b0;
                        trigCnt_q <= '0;
                        binCnt_q  <= '0;
                        hdrIdx_q  <= '0;
`ifdef G2_READOUT_CKSUM_EN
                        sum_q     <= '0;
`endif
                    end
                end
                TRIG: begin
                    if (trigCnt_q == TW'(TRIG_LEN - 1)) begin
                        g2Rst_q  <= 1'b1;
                        state_q  <= HDR;
                        ctlD_q   <= SYNC0;
                        ctlV_q   <= 1'b1;
                        hdrIdx_q <= '0;
                    end else begin
                        trigCnt_q <= trigCnt_q + 1'b1;
                    end
                end
                HDR: begin
                    if (ctlTake) begin
                        hdrIdx_q <= hdrIdx_q + 1'b1;
`ifdef G2_READOUT_CKSUM_EN
                        if (hdrIdx_q[1]) begin
                            sum_q <= sum_q + ctlD_q;
                        end
`endif
                        case (hdrIdx_q)
                            2'd0:    ctlD_q <= SYNC1;
                            2'd1:    ctlD_q <= CNT16[7:0];
                            2'd2:    ctlD_q <= CNT16[15:8];
                            default: begin
                                ctlV_q  <= 1'b0;
                                state_q <= BIN;
                            end
                        endcase
                    end
                end
                BIN: begin
                    if (frameEnd) begin
`ifdef G2_READOUT_CKSUM_EN
                        state_q <= CKS;
                        ctlD_q  <= cksByte_d;
                        ctlV_q  <= 1'b1;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef G2_READOUT_CKSUM_EN
                CKS: begin
                    if (ctlTake) begin
                        ctlV_q  <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_g2_readout.sv
// Directed bench for g2_readout with NBINS=4, BIN_W=32, TRIG_LEN=2.
// Adapts its expected frame to whether G2_READOUT_CKSUM_EN is defined.
module tb_g2_readout;
    import g2_readout_pkg::*;

    localparam int NB   = 4;
    localparam int BW   = 32;
`ifdef G2_READOUT_CKSUM_EN
    localparam bit CKS_ON = 1'b1;
`else
    localparam bit CKS_ON = 1'b0;
`endif
    localparam int FLEN = frame_len(NB, BW, CKS_ON);

    logic          clk;
    logic          RST;
    logic          start;
    logic          busy;
    logic          done;
    logic          g2Rst;
    logic [BW-1:0] g2Dat;
    logic          g2V;
    logic          g2R;
    logic [7:0]    oD;
    logic          oV;
    logic          oR;

    int checks;
    int errors;

    logic [7:0] expBytes[$];
    logic [7:0] rxBytes[$];

    bit   bpMode;
    bit   gapMode;
    int   wordIdx;
    int   gapCnt;
    int   gapErr;
    int   startLeft;
    int   cyc;
    int   firstCyc;
    int   lastCyc;
    int   doneCyc;
    int   doneCnt;
    int   lowCyc;
    int   fallCnt;
    logic prevG2Rst;
    bit   prevStall;
    logic [7:0] prevStallD;
    int   stableErr;

    g2_readout #(
        .NBINS    (NB),
        .BIN_W    (BW),
        .TRIG_LEN (2)
    ) dut (
        .clk   (clk),
        .RST   (RST),
        .start (start),
        .busy  (busy),
        .done  (done),
        .g2Rst (g2Rst),
        .g2Dat (g2Dat),
        .g2V   (g2V),
        .g2R   (g2R),
        .oD    (oD),
        .oV    (oV),
        .oR    (oR)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived frame: sync, count 4, words 04030201 + i*01010101, checksum 0xBC.
    task automatic buildExpected();
        expBytes.delete();
        expBytes.push_back(8'hA5);
        expBytes.push_back(8'h5A);
        expBytes.push_back(8'h04);
        expBytes.push_back(8'h00);
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 4; k++) begin
                expBytes.push_back(8'(k + 1 + i));
            end
        end
        if (CKS_ON) begin
            expBytes.push_back(8'hBC);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs just after the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        if (!g2Rst) lowCyc++;
        if (prevG2Rst && !g2Rst) fallCnt++;
        prevG2Rst = g2Rst;
        if (done) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (prevStall && (!oV || oD !== prevStallD)) stableErr++;
        prevStall  = oV && !oR;
        prevStallD = oD;
        if (oV && oR) begin
            rxBytes.push_back(oD);
            if (firstCyc < 0) firstCyc = cyc;
            lastCyc = cyc;
        end
        if (gapMode && !g2V && gapCnt >= 6 && gapCnt <= 50 && oV) gapErr++;
        if (g2V && g2R) wordIdx++;
        @(posedge clk);
        #1;
        g2Dat = 32'(32'h04030201 + wordIdx * 32'h01010101);
        if (gapMode && wordIdx == 2 && gapCnt < 50) begin
            g2V = 1'b0;
            gapCnt++;
        end else begin
            g2V = 1'b1;
        end
        oR = bpMode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        if (startLeft > 0) begin
            start = 1'b1;
            startLeft--;
        end else begin
            start = 1'b0;
        end
    endtask

    // Clears bench bookkeeping and begins a readout request held high for 8 cycles.
    task automatic beginFrame(input int mode);
        bpMode     = (mode == 1);
        gapMode    = (mode == 2);
        wordIdx    = 0;
        gapCnt     = 0;
        gapErr     = 0;
        cyc        = 0;
        firstCyc   = -1;
        lastCyc    = -1;
        doneCyc    = -1;
        doneCnt    = 0;
        lowCyc     = 0;
        fallCnt    = 0;
        prevG2Rst  = g2Rst;
        prevStall  = 1'b0;
        stableErr  = 0;
        rxBytes.delete();
        g2Dat      = 32'h04030201;
        g2V        = 1'b1;
        oR         = 1'b1;
        start      = 1'b1;
        startLeft  = 7;
    endtask

    // Runs one complete frame and checks its contents and timing.
    task automatic runFrame(input int mode, input string name);
        int n;
        int s;
        beginFrame(mode);
        n = 0;
        while (doneCnt == 0 && n < 3000) begin
            applyStimulus();
            n++;
        end
        if (n >= 3000) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus();

        checkOutput({name, "_len"}, rxBytes.size(), FLEN);
        for (int i = 0; i < FLEN; i++) begin
            if (i < rxBytes.size()) begin
                checkOutput($sformatf("%s_b%0d", name, i), rxBytes[i], expBytes[i]);
            end
        end
        s = 0;
        for (int i = 2; i < rxBytes.size(); i++) s = (s + rxBytes[i]) % 256;
        checkOutput({name, "_sum"}, s, CKS_ON ? 0 : 'h44);
        checkOutput({name, "_doneCnt"}, doneCnt, 1);
        checkOutput({name, "_doneLat"}, doneCyc - lastCyc, 1);
        checkOutput({name, "_trigLow"}, lowCyc, 2);
        checkOutput({name, "_trigFalls"}, fallCnt, 1);
        checkOutput({name, "_busyEnd"}, busy, 1'b0);
        checkOutput({name, "_words"}, wordIdx, NB);
        checkOutput({name, "_stable"}, stableErr, 0);
        if (mode == 0) checkOutput({name, "_tput"}, lastCyc - firstCyc + 1, FLEN);
        if (mode == 2) begin
            checkOutput({name, "_gapLen"}, gapCnt, 50);
            checkOutput({name, "_gapIdle"}, gapErr, 0);
        end
    endtask

    // Main sequence: reset state, mid-frame reset, then plain, backpressured and stalled frames.
    initial begin
        int n;
        bit sawBin;
        checks    = 0;
        errors    = 0;
        RST       = 1'b0;
        start     = 1'b0;
        g2V       = 1'b0;
        g2Dat     = '0;
        oR        = 1'b0;
        startLeft = 0;
        buildExpected();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_g2Rst", g2Rst, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_oV", oV, 1'b0);
        checkOutput("rst_oD", oD, 8'h00);
        checkOutput("rst_g2R", g2R, 1'b0);
        RST = 1'b1;
        applyStimulus();

        beginFrame(0);
        n = 0;
        sawBin = 1'b0;
        while (!sawBin && n < 200) begin
            applyStimulus();
            startLeft = 0;
            start     = 1'b0;
            sawBin    = (rxBytes.size() >= 6) && oV;
            n++;
        end
        checkOutput("midrst_reachedBin", sawBin, 1'b1);
        #3;
        RST = 1'b0;
        #1;
        checkOutput("midrst_oV", oV, 1'b0);
        checkOutput("midrst_g2R", g2R, 1'b0);
        checkOutput("midrst_g2Rst", g2Rst, 1'b1);
        checkOutput("midrst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        RST       = 1'b1;
        fallCnt   = 0;
        prevG2Rst = g2Rst;
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("midrst_noTrig", fallCnt, 0);
        checkOutput("midrst_idleBusy", busy, 1'b0);

        runFrame(0, "plain");
        runFrame(1, "bp");
        runFrame(2, "gap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
